piso_serializer: RTL

- Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with frame markers.
- Transmit-side counterpart to the team's serial-capture flip-flop chains; drives a bit-serial link into a serial-in receiver register.
- Built from single-bit registered storage with asynchronous reset and synchronous clear, matching the team's flip-flop primitives.

---
 rtl/piso_serializer.sv | 74 +++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load and frame markers.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear_n,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   output logic             o_sout,
   output logic             o_sout_valid,
   output logic             o_frame_start,
   output logic             o_frame_end,
   output logic             o_busy
);
`ifdef PISO_SERIALIZER_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int CW = $clog2(FL);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t          r_state, w_state_nx;
   logic [FL-1:0]   r_sh, w_word, w_sh_nx;
   logic [CW-1:0]   r_cnt;
   logic            r_first, w_load, w_last;
`ifdef PISO_SERIALIZER_PARITY_EN
   // parity rides in the tail slot so it leaves after the last data bit
   assign w_word = (LSB_FIRST != 0) ? {^i_din, i_din} : {i_din, ^i_din};
`else
   assign w_word = i_din;
`endif
   assign w_sh_nx = (LSB_FIRST != 0) ? {1'b0, r_sh[FL-1:1]} : {r_sh[FL-2:0], 1'b0};
   assign w_last  = (r_state == SHIFT) && (r_cnt == '0);
   assign w_load  = i_load_valid && o_load_ready;
   always_comb begin
      w_state_nx = r_state;
      if (!i_clear_n)  w_state_nx = IDLE;
      else if (w_load) w_state_nx = SHIFT;
      else if (w_last) w_state_nx = IDLE;
   end
   assign o_load_ready  = !i_reset && ((r_state == IDLE) || w_last);
   assign o_sout_valid  = (r_state == SHIFT);
   assign o_busy        = o_sout_valid;
   assign o_sout        = o_sout_valid && ((LSB_FIRST != 0) ? r_sh[0] : r_sh[FL-1]);
   assign o_frame_start = o_sout_valid && r_first;
   assign o_frame_end   = w_last;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         if (!i_clear_n) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
         end else if (w_load) begin
            r_sh    <= w_word;
            r_cnt   <= CW'(FL - 1);
            r_first <= 1'b1;
         end else if (r_state == SHIFT) begin
            r_sh    <= w_sh_nx;
            r_cnt   <= w_last ? '0 : r_cnt - 1'b1;
            r_first <= 1'b0;
         end
      end
   end
endmodule
